// File: rtl/ifu_redirect_ctrl.sv
// ifu_redirect_ctrl: redirect arbiter and sequencer for the IFU1 PC register.
// Picks one of trap/xret, branch mispredict, fence.i and BHT redirects by fixed
// priority, holds a trap/branch redirect across IF stalls, and runs the fence.i
// I-cache invalidate handshake with a sticky timeout flag.
// Optional macro IFU_REDIRECT_PERF_EN: enables per-source accepted-redirect counters.
module ifu_redirect_ctrl #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            fencei_valid,
    input  logic [XLEN-1:0] fencei_target,
    input  logic            bht_valid,
    input  logic [XLEN-1:0] bht_target,
    output logic            ic_flush_req,
    input  logic            ic_flush_done,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic            ctrl_stall_if,
    output logic            flush_ifid,
    output logic            flush_err,
    output logic [31:0]     perf_cnt_trap,
    output logic [31:0]     perf_cnt_br,
    output logic [31:0]     perf_cnt_fencei,
    output logic [31:0]     perf_cnt_bht
);

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    localparam logic [9:0] TMO = 10'(FLUSH_TIMEOUT);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]      pend_prio_q, pend_prio_d;
    logic [9:0]      tmo_cnt_q, tmo_cnt_d;
    logic            flush_err_q, flush_err_d;

    logic            req_valid;
    logic [1:0]      req_prio;
    logic [XLEN-1:0] req_tgt;
    logic            ovr;

    // Latchable request (trap beats branch) and whether it outranks the held one
    always_comb begin
        req_valid = trap_valid | br_valid;
        req_prio  = trap_valid ? 2'd0 : 2'd1;
        req_tgt   = trap_valid ? trap_target : br_target;
        ovr       = req_valid && (req_prio < pend_prio_q);
    end

    // Next-state, latch update and redirect outputs
    always_comb begin
        state_d     = state_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
        tmo_cnt_d   = tmo_cnt_q;
        flush_err_d = flush_err_q;
        pc_src      = 1'b0;
        pc_target   = '0;
        flush_ifid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pc_src    = 1'b1;
                    pc_target = req_tgt;
                    if (!stall_if) begin
                        flush_ifid = 1'b1;
                    end else begin
                        pend_tgt_d  = req_tgt;
                        pend_prio_d = req_prio;
                        state_d     = PEND;
                    end
                end else if (fencei_valid) begin
                    pend_tgt_d  = fencei_target;
                    pend_prio_d = 2'd2;
                    tmo_cnt_d   = '0;
                    state_d     = FLUSH;
                end else if (bht_valid) begin
                    // Prediction is a pass-through; it is lost if IF is stalled.
                    pc_src    = 1'b1;
                    pc_target = bht_target;
                end
            end
            PEND: begin
                pc_src    = 1'b1;
                pc_target = ovr ? req_tgt : pend_tgt_q;
                if (!stall_if) begin
                    flush_ifid  = 1'b1;
                    pend_prio_d = 2'd3;
                    state_d     = IDLE;
                end else if (ovr) begin
                    pend_tgt_d  = req_tgt;
                    pend_prio_d = req_prio;
                end
            end
            FLUSH: begin
                // A trap/branch may replace the fence.i target, but the
                // invalidate in flight always runs to completion.
                if (ovr) begin
                    pend_tgt_d  = req_tgt;
                    pend_prio_d = req_prio;
                end
                if (tmo_cnt_q != TMO) begin
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                end
                if (tmo_cnt_d == TMO) begin
                    flush_err_d = 1'b1;
                end
                if (ic_flush_done) begin
                    state_d = PEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_tgt_q  <= '0;
            pend_prio_q <= 2'd3;
            tmo_cnt_q   <= '0;
            flush_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
            tmo_cnt_q   <= tmo_cnt_d;
            flush_err_q <= flush_err_d;
        end
    end

    assign ic_flush_req  = (state_q == FLUSH);
    assign ctrl_stall_if = (state_q == FLUSH);
    assign flush_err     = flush_err_q;

`ifdef IFU_REDIRECT_PERF_EN
    logic [31:0] perf_q [4];
    logic [31:0] perf_d [4];
    logic        acc;
    logic [1:0]  acc_src;

    // Identify which source the PC register takes this cycle and bump its counter
    always_comb begin
        acc     = pc_src & ~stall_if & ~ctrl_stall_if;
        acc_src = 2'd3;
        if (state_q == PEND) begin
            acc_src = ovr ? req_prio : pend_prio_q;
        end else if (req_valid) begin
            acc_src = req_prio;
        end
        for (int i = 0; i < 4; i++) begin
            perf_d[i] = perf_q[i];
        end
        if (acc) begin
            perf_d[acc_src] = perf_q[acc_src] + 32'd1;
        end
    end

    // Counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                perf_q[i] <= perf_d[i];
            end
        end
    end

    assign perf_cnt_trap   = perf_q[0];
    assign perf_cnt_br     = perf_q[1];
    assign perf_cnt_fencei = perf_q[2];
    assign perf_cnt_bht    = perf_q[3];
`else
    assign perf_cnt_trap   = '0;
    assign perf_cnt_br     = '0;
    assign perf_cnt_fencei = '0;
    assign perf_cnt_bht    = '0;
`endif

endmodule

// File: tb/tb_ifu_redirect_ctrl.sv
// Testbench for ifu_redirect_ctrl: directed scenarios with a target scoreboard.
// Every accepted redirect pops the queue of expected PC targets.
module tb_ifu_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int FT   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall_if = 1'b0;
    logic            trap_valid = 1'b0;
    logic [XLEN-1:0] trap_target = '0;
    logic            br_valid = 1'b0;
    logic [XLEN-1:0] br_target = '0;
    logic            fencei_valid = 1'b0;
    logic [XLEN-1:0] fencei_target = '0;
    logic            bht_valid = 1'b0;
    logic [XLEN-1:0] bht_target = '0;
    logic            ic_flush_done = 1'b0;
    logic            ic_flush_req;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            ctrl_stall_if;
    logic            flush_ifid;
    logic            flush_err;
    logic [31:0]     perf_cnt_trap, perf_cnt_br, perf_cnt_fencei, perf_cnt_bht;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] exp_q [$];

    ifu_redirect_ctrl #(.XLEN(XLEN), .FLUSH_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .br_valid(br_valid), .br_target(br_target),
        .fencei_valid(fencei_valid), .fencei_target(fencei_target),
        .bht_valid(bht_valid), .bht_target(bht_target),
        .ic_flush_req(ic_flush_req), .ic_flush_done(ic_flush_done),
        .pc_src(pc_src), .pc_target(pc_target),
        .ctrl_stall_if(ctrl_stall_if), .flush_ifid(flush_ifid),
        .flush_err(flush_err),
        .perf_cnt_trap(perf_cnt_trap), .perf_cnt_br(perf_cnt_br),
        .perf_cnt_fencei(perf_cnt_fencei), .perf_cnt_bht(perf_cnt_bht)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        trap_valid = 1'b0; br_valid = 1'b0; fencei_valid = 1'b0;
        bht_valid = 1'b0; stall_if = 1'b0; ic_flush_done = 1'b0;
    endtask

    // Scoreboard: each accepted redirect must match the oldest expected target
    always @(negedge clk) begin
        if (!rst && pc_src && !stall_if && !ctrl_stall_if) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_accept", {32'd0, pc_target}, 64'hDEAD);
            end else begin
                chk("sb_target", {32'd0, pc_target}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        cyc(); cyc();
        smp();
        chk("rst_pc_src", pc_src, 0);
        chk("rst_ic_req", ic_flush_req, 0);
        chk("rst_ctrl_stall", ctrl_stall_if, 0);
        chk("rst_flush_ifid", flush_ifid, 0);
        chk("rst_err", flush_err, 0);
        chk("rst_perf_br", perf_cnt_br, 0);
        cyc();
        rst = 1'b0;

        // Unstalled branch: same-cycle redirect with flush
        br_valid = 1'b1; br_target = 32'h8000_0100; exp_q.push_back(32'h8000_0100);
        smp();
        chk("br_pc_src", pc_src, 1);
        chk("br_target", pc_target, 32'h8000_0100);
        chk("br_flush", flush_ifid, 1);
        cyc(); clr();
        smp();
        chk("br_idle_after", pc_src, 0);
        cyc();

        // Branch held over three stalled cycles
        br_valid = 1'b1; br_target = 32'h8000_0200; stall_if = 1'b1;
        exp_q.push_back(32'h8000_0200);
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk("pend_pc_src", pc_src, 1);
            chk("pend_target", pc_target, 32'h8000_0200);
            chk("pend_no_flush", flush_ifid, 0);
            cyc();
            br_valid = 1'b0;
        end
        stall_if = 1'b0;
        smp();
        chk("pend_accept_flush", flush_ifid, 1);
        cyc();
        smp();
        chk("pend_done_pc_src", pc_src, 0);
        chk("pend_done_flush", flush_ifid, 0);
        cyc();

        // Pending branch replaced by trap; later lower-priority requests ignored
        br_valid = 1'b1; br_target = 32'h8000_0200; stall_if = 1'b1;
        cyc();
        br_valid = 1'b0; trap_valid = 1'b1; trap_target = 32'h8000_0004;
        exp_q.push_back(32'h8000_0004);
        smp();
        chk("ovr_target", pc_target, 32'h8000_0004);
        cyc();
        trap_valid = 1'b0; bht_valid = 1'b1; bht_target = 32'h8000_0040;
        br_valid = 1'b1; br_target = 32'h8000_0300;
        smp();
        chk("ovr_ignore_low", pc_target, 32'h8000_0004);
        cyc();
        clr();
        smp();
        chk("ovr_apply_flush", flush_ifid, 1);
        chk("ovr_apply_target", pc_target, 32'h8000_0004);
        cyc();

        // Trap and BHT together: trap wins, prediction dropped
        trap_valid = 1'b1; trap_target = 32'h8000_0004;
        bht_valid = 1'b1; bht_target = 32'h8000_0040;
        exp_q.push_back(32'h8000_0004);
        smp();
        chk("prio_target", pc_target, 32'h8000_0004);
        cyc(); clr();
        smp();
        chk("prio_bht_dropped", pc_src, 0);
        cyc();

        // BHT while stalled: presented but not accepted, no flush
        bht_valid = 1'b1; bht_target = 32'h8000_0050; stall_if = 1'b1;
        smp();
        chk("bht_stall_src", pc_src, 1);
        chk("bht_stall_flush", flush_ifid, 0);
        cyc(); clr();
        smp();
        chk("bht_stall_gone", pc_src, 0);
        cyc();

        // fence.i with invalidate completing on the fifth flush cycle
        fencei_valid = 1'b1; fencei_target = 32'h8000_0010;
        exp_q.push_back(32'h8000_0010);
        smp();
        chk("fencei_no_src", pc_src, 0);
        chk("fencei_no_req_yet", ic_flush_req, 0);
        cyc(); clr();
        for (int k = 1; k <= 5; k++) begin
            ic_flush_done = (k == 5);
            smp();
            chk("flush_req", ic_flush_req, 1);
            chk("flush_ctrl_stall", ctrl_stall_if, 1);
            chk("flush_no_src", pc_src, 0);
            cyc();
        end
        ic_flush_done = 1'b0;
        smp();
        chk("fencei_req_drop", ic_flush_req, 0);
        chk("fencei_apply_src", pc_src, 1);
        chk("fencei_apply_target", pc_target, 32'h8000_0010);
        chk("fencei_apply_flush", flush_ifid, 1);
        cyc();

        // Trap arriving mid-flush replaces the fence.i target
        fencei_valid = 1'b1; fencei_target = 32'h8000_0030;
        cyc(); clr();
        trap_valid = 1'b1; trap_target = 32'h8000_0008;
        exp_q.push_back(32'h8000_0008);
        smp();
        chk("flush_trap_no_src", pc_src, 0);
        cyc();
        trap_valid = 1'b0; ic_flush_done = 1'b1;
        smp();
        chk("flush_trap_req", ic_flush_req, 1);
        cyc();
        ic_flush_done = 1'b0;
        smp();
        chk("flush_trap_target", pc_target, 32'h8000_0008);
        cyc();

        // Invalidate never completes: sticky error after FT flush cycles
        fencei_valid = 1'b1; fencei_target = 32'h8000_0020;
        cyc(); clr();
        for (int k = 1; k <= FT + 1; k++) begin
            smp();
            chk("tmo_err", flush_err, (k > FT) ? 1 : 0);
            chk("tmo_req_held", ic_flush_req, 1);
            cyc();
        end
        rst = 1'b1;
        smp();
        chk("tmo_req_before_rst_edge", ic_flush_req, 1);
        cyc();
        smp();
        chk("rst_flush_req", ic_flush_req, 0);
        chk("rst_flush_ctrl", ctrl_stall_if, 0);
        chk("rst_flush_err", flush_err, 0);
        chk("rst_flush_src", pc_src, 0);
        chk("rst_flush_ifid", flush_ifid, 0);
        cyc();
        rst = 1'b0;

        // Counter scenario: three branches, two predictions, one stalled prediction
        for (int k = 0; k < 3; k++) begin
            br_valid = 1'b1; br_target = 32'h8000_1000 + 32'(k * 4);
            exp_q.push_back(32'h8000_1000 + 32'(k * 4));
            cyc();
        end
        clr();
        for (int k = 0; k < 2; k++) begin
            bht_valid = 1'b1; bht_target = 32'h8000_2000 + 32'(k * 4);
            exp_q.push_back(32'h8000_2000 + 32'(k * 4));
            cyc();
        end
        bht_valid = 1'b1; stall_if = 1'b1;
        cyc();
        clr();
        smp();
`ifdef IFU_REDIRECT_PERF_EN
        chk("perf_br", perf_cnt_br, 3);
        chk("perf_bht", perf_cnt_bht, 2);
`else
        chk("perf_br", perf_cnt_br, 0);
        chk("perf_bht", perf_cnt_bht, 0);
`endif
        chk("perf_trap", perf_cnt_trap, 0);
        chk("perf_fencei", perf_cnt_fencei, 0);
        cyc();

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
